// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the shared single-port 256x8 memory
// Fixed CPU priority with loader aging; 2-cycle request-to-response pipeline.
module mem_arbiter #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8,
  parameter int MAX_WAIT      = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
  input  logic [WIDTH-1:0]         cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [WIDTH-1:0]         cpu_rdata,
  input  logic                     ld_req,
  input  logic                     ld_we,
  input  logic [RAM_ADDR_BITS-1:0] ld_adr,
  input  logic [WIDTH-1:0]         ld_wdata,
  output logic                     ld_gnt,
  output logic                     ld_rvalid,
  output logic [WIDTH-1:0]         ld_rdata,
  output logic                     mem_memwrite,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_writedata,
  input  logic [WIDTH-1:0]         mem_memdata,
  output logic                     busy
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LD} owner_t;

  owner_t     owner;
  logic [3:0] wait_cnt;

  // Loader takes the slot when the CPU is idle or the loader has aged out.
  always_comb begin
    ld_gnt  = ld_req && (!cpu_req || (wait_cnt >= 4'(MAX_WAIT)));
    cpu_gnt = cpu_req && !ld_gnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (ld_gnt || !ld_req) begin
      wait_cnt <= 4'd0;
    end else if (cpu_gnt && (wait_cnt != 4'hF)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Issue stage: the memory samples these registers on the next falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_memwrite  <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      owner         <= OWN_NONE;
      busy          <= 1'b0;
    end else begin
      busy <= cpu_gnt || ld_gnt;
      if (ld_gnt) begin
        mem_memwrite  <= ld_we;
        mem_adr       <= ld_adr;
        mem_writedata <= ld_wdata;
        owner         <= OWN_LD;
      end else if (cpu_gnt) begin
        mem_memwrite  <= cpu_we;
        mem_adr       <= cpu_adr;
        mem_writedata <= cpu_wdata;
        owner         <= OWN_CPU;
      end else begin
        mem_memwrite  <= 1'b0;
        owner         <= OWN_NONE;
      end
    end
  end

  // Response stage: writes also pulse rvalid, returning the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      cpu_rvalid <= (owner == OWN_CPU);
      ld_rvalid  <= (owner == OWN_LD);
      if (owner == OWN_CPU) cpu_rdata <= mem_memdata;
      if (owner == OWN_LD)  ld_rdata  <= mem_memdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Behavioural memory plus an access-level reference model and scoreboard.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [7:0] cpu_adr = '0, cpu_wdata = '0, ld_adr = '0, ld_wdata = '0;
  logic       cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid, mem_memwrite, busy;
  logic [7:0] cpu_rdata, ld_rdata, mem_adr, mem_writedata;
  logic [7:0] mem_memdata = '0;
  logic       preload = 1'b1;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.WIDTH(8), .RAM_ADDR_BITS(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_memwrite(mem_memwrite), .mem_adr(mem_adr), .mem_writedata(mem_writedata),
    .mem_memdata(mem_memdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    case (a)
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h05:   return 8'h3C;
      8'h30:   return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  // External memory: reads old contents, then the nonblocking write lands.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      mem_memdata <= mem[mem_adr];
      if (mem_memwrite) mem[mem_adr] <= mem_writedata;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit         v;
    bit         ld;
    bit         we;
    logic [7:0] adr;
    logic [7:0] wd;
    logic [7:0] rd;
  } acc_t;

  logic [7:0] ref_mem [256];
  acc_t       st1, st2;
  int         m_wait;
  logic [7:0] e_adr, e_wd, e_cpu_rd, e_ld_rd;

  task automatic model_reset();
    st1 = '{default: '0};
    st2 = '{default: '0};
    m_wait = 0;
    e_adr = 8'h00; e_wd = 8'h00; e_cpu_rd = 8'h00; e_ld_rd = 8'h00;
  endtask

  // One clock cycle: drive requests, check every output, advance the model.
  task automatic cycle(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic lr, input logic lw, input logic [7:0] la, input logic [7:0] ldd,
                       output bit cg, output bit lg);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wdata = cd;
    ld_req = lr; ld_we = lw; ld_adr = la; ld_wdata = ldd;
    #3;
    lg = lr && (!cr || m_wait >= MAX_WAIT);
    cg = cr && !lg;
    check("cpu_gnt", 8'(cpu_gnt), 8'(cg));
    check("ld_gnt", 8'(ld_gnt), 8'(lg));
    check("mem_memwrite", 8'(mem_memwrite), 8'(st1.v && st1.we));
    check("mem_adr", mem_adr, e_adr);
    check("mem_writedata", mem_writedata, e_wd);
    check("busy", 8'(busy), 8'(st1.v));
    if (st2.v) begin
      if (st2.ld) e_ld_rd = st2.rd;
      else        e_cpu_rd = st2.rd;
    end
    check("cpu_rvalid", 8'(cpu_rvalid), 8'(st2.v && !st2.ld));
    check("ld_rvalid", 8'(ld_rvalid), 8'(st2.v && st2.ld));
    check("cpu_rdata", cpu_rdata, e_cpu_rd);
    check("ld_rdata", ld_rdata, e_ld_rd);
    st2 = st1;
    if (st1.v) begin
      st2.rd = ref_mem[st1.adr];
      if (st1.we) ref_mem[st1.adr] = st1.wd;
    end
    st1.v  = cg || lg;
    st1.ld = lg;
    st1.we = lg ? lw : cw;
    st1.adr = lg ? la : ca;
    st1.wd  = lg ? ldd : cd;
    if (st1.v) begin
      e_adr = st1.adr;
      e_wd  = st1.wd;
    end
    if (lr && !lg) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else           m_wait = 0;
  endtask

  task automatic idle(input int n);
    bit g1, g2;
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, g1, g2);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cpu_req = 1'b0; ld_req = 1'b0;
    #1;
    check("rst_memwrite", 8'(mem_memwrite), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_mem_adr", mem_adr, 8'h00);
    check("rst_cpu_rvalid", 8'(cpu_rvalid), 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit g1, g2;
    bit cp, lp;
    logic cw_r, lw_r;
    logic [7:0] ca_r, cd_r, la_r, ld_r;
    cp = 0; lp = 0; cw_r = 0; lw_r = 0;
    ca_r = 8'h00; cd_r = 8'h00; la_r = 8'h00; ld_r = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();

    #2;
    check("reset_memwrite", 8'(mem_memwrite), 8'h00);
    check("reset_adr", mem_adr, 8'h00);
    check("reset_wdata", mem_writedata, 8'h00);
    check("reset_busy", 8'(busy), 8'h00);
    check("reset_rvalid", {6'b0, cpu_rvalid, ld_rvalid}, 8'h00);
    check("reset_rdata", cpu_rdata | ld_rdata, 8'h00);
    @(negedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    cycle(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, g1, g2);
    idle(2);
    check("t1_cpu_rdata", cpu_rdata, 8'h3C);
    check("t1_ld_rdata", ld_rdata, 8'h00);
    idle(1);

    cycle(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, g1, g2);
    cycle(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, g1, g2);
    idle(3);
    check("t2_read_after_write", cpu_rdata, 8'h5A);

    for (int i = 0; i < 12; i++)
      cycle(1, 0, 8'h05, 8'h00, 1, 0, 8'h02, 8'h00, g1, g2);
    idle(3);

    for (int i = 0; i < 4; i++)
      cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h20 + 8'(i), 8'hA1 + 8'(i), g1, g2);
    idle(3);
    for (int i = 0; i < 4; i++)
      check("t4_mem", mem[8'h20 + i], 8'hA1 + 8'(i));

    cycle(1, 1, 8'h30, 8'h99, 0, 0, 8'h00, 8'h00, g1, g2);
    reset_mid();
    idle(2);
    check("t5_mem_30", mem[8'h30], 8'h77);
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 8'h30, 8'h00, 1, 0, 8'h01, 8'h00, g1, g2);
    idle(3);

    cycle(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, g1, g2);
    cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, g1, g2);
    idle(4);

    // Random traffic; a pending request holds its fields until granted.
    for (int k = 0; k < 600; k++) begin
      if (!cp) begin
        cp = ($urandom_range(0, 9) < 6);
        cw_r = 1'($urandom_range(0, 1));
        ca_r = 8'($urandom_range(0, 31));
        cd_r = 8'($urandom);
      end
      if (!lp) begin
        lp = ($urandom_range(0, 9) < 5);
        lw_r = 1'($urandom_range(0, 1));
        la_r = 8'($urandom_range(0, 31));
        ld_r = 8'($urandom);
      end
      cycle(cp, cw_r, ca_r, cd_r, lp, lw_r, la_r, ld_r, g1, g2);
      if (g1) cp = 0;
      if (g2) lp = 0;
    end
    idle(4);
    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
